// File: rtl/mem_arbiter_pkg.sv
// Shared encodings for the external RAM arbiter: FSM states, access-size codes,
// grant ids, and the size-to-byte-count decode.
package mem_arbiter_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_IFETCH = 3'd1,
    ST_DREAD  = 3'd2,
    ST_DWRITE = 3'd3,
    ST_DDONE  = 3'd4
  } state_t;

  typedef enum logic [1:0] {
    SZ_1B  = 2'b00,
    SZ_2B  = 2'b01,
    SZ_4B  = 2'b10,
    SZ_BAD = 2'b11
  } dsize_t;

  typedef enum logic {
    GNT_DATA   = 1'b0,
    GNT_ICACHE = 1'b1
  } gnt_t;

  // The illegal code degrades to a single-byte access rather than hanging the port.
  function automatic logic [2:0] size_bytes(input logic [1:0] sz);
    case (dsize_t'(sz))
      SZ_2B:   return 3'd2;
      SZ_4B:   return 3'd4;
      default: return 3'd1;
    endcase
  endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// Requester-side and RAM-side signals of the byte-wide memory arbiter.
// slave = arbiter view, master = requester/RAM environment view.
interface mem_arbiter_if #(
  parameter int ADDR_W = 17
);
  logic              flush;
  logic              icache_get_en;
  logic [ADDR_W-1:0] icache_addr;
  logic              icache_out_en;
  logic [7:0]        icache_byte;
  logic              data_req;
  logic              data_we;
  logic [1:0]        data_size;
  logic [ADDR_W-1:0] data_addr;
  logic [31:0]       data_wdata;
  logic              data_done;
  logic [31:0]       data_rdata;
  logic [7:0]        mem_din;
  logic              io_buffer_full;
  logic [ADDR_W-1:0] mem_a;
  logic [7:0]        mem_dout;
  logic              mem_wr;

  modport slave (
    input  flush, icache_get_en, icache_addr, data_req, data_we, data_size,
           data_addr, data_wdata, mem_din, io_buffer_full,
    output icache_out_en, icache_byte, data_done, data_rdata, mem_a, mem_dout, mem_wr
  );

  modport master (
    output flush, icache_get_en, icache_addr, data_req, data_we, data_size,
           data_addr, data_wdata, mem_din, io_buffer_full,
    input  icache_out_en, icache_byte, data_done, data_rdata, mem_a, mem_dout, mem_wr
  );
endinterface

// File: rtl/mem_arbiter.sv
// Owner of the byte-wide RAM port: round-robin between ICache fill stream and one
// data requester, sequencing 1/2/4-byte little-endian loads/stores.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int ADDR_W = 17
) (
  input  logic         clk,
  input  logic         rst,
  mem_arbiter_if.slave bus
);

  state_t            state, state_nxt;
  gnt_t              last_grant;
  logic [ADDR_W-1:0] addr_q;
  logic [ADDR_W-1:0] mem_a_q;
  logic [7:0]        mem_dout_q;
  logic [3:0][7:0]   wdata_q;
  logic [3:0][7:0]   rdata_q;
  logic              we_q;
  logic [2:0]        n_q;
  logic [2:0]        k_q;
  logic              fetch_vld_q;

  logic              grant_i, grant_d;
  logic              fetch_issue, rd_issue, rd_capture, wr_fire;
  logic [1:0]        cap_idx;
  logic [ADDR_W-1:0] byte_addr;

  assign byte_addr   = addr_q + ADDR_W'(k_q);
  assign fetch_issue = (state == ST_IFETCH) && bus.icache_get_en && !bus.flush;
  // k_q counts issued bytes; one extra DREAD cycle with k_q==n_q catches the last return.
  assign rd_issue    = (state == ST_DREAD) && (k_q != n_q);
  assign rd_capture  = (state == ST_DREAD) && (k_q != 3'd0);
  assign cap_idx     = k_q[1:0] - 2'd1;
  assign wr_fire     = (state == ST_DWRITE) && !bus.io_buffer_full;

  always_ff @(posedge clk) begin
    if (!rst) state <= ST_IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    grant_i   = 1'b0;
    grant_d   = 1'b0;
    case (state)
      ST_IDLE: begin
        if (bus.data_req && bus.icache_get_en) begin
          if (last_grant == GNT_DATA) grant_i = 1'b1;
          else                        grant_d = 1'b1;
        end else if (bus.data_req) begin
          grant_d = 1'b1;
        end else if (bus.icache_get_en) begin
          grant_i = 1'b1;
        end
        if (grant_i)      state_nxt = ST_IFETCH;
        else if (grant_d) state_nxt = bus.data_we ? ST_DWRITE : ST_DREAD;
      end
      ST_IFETCH: if (bus.flush || !bus.icache_get_en) state_nxt = ST_IDLE;
      ST_DREAD:  if (k_q == n_q) state_nxt = ST_DDONE;
      ST_DWRITE: if (wr_fire && (k_q == n_q - 3'd1)) state_nxt = ST_DDONE;
      ST_DDONE:  state_nxt = ST_IDLE;
      default:   state_nxt = ST_IDLE;
    endcase
  end

  // RAM address/data hold their last driven value whenever no access is in flight.
  always_comb begin
    bus.mem_a    = mem_a_q;
    bus.mem_dout = mem_dout_q;
    bus.mem_wr   = 1'b0;
    case (state)
      ST_IFETCH: bus.mem_a = bus.icache_addr;
      ST_DREAD:  if (rd_issue) bus.mem_a = byte_addr;
      ST_DWRITE: begin
        bus.mem_a    = byte_addr;
        bus.mem_dout = wdata_q[k_q[1:0]];
        bus.mem_wr   = wr_fire;
      end
      default: ;
    endcase
    bus.icache_out_en = (state == ST_IFETCH) && fetch_vld_q && !bus.flush;
    bus.icache_byte   = bus.icache_out_en ? bus.mem_din : 8'h00;
    bus.data_done     = (state == ST_DDONE);
    bus.data_rdata    = (bus.data_done && !we_q) ? rdata_q : 32'h0;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      last_grant  <= GNT_DATA;
      addr_q      <= '0;
      mem_a_q     <= '0;
      mem_dout_q  <= '0;
      wdata_q     <= '0;
      rdata_q     <= '0;
      we_q        <= 1'b0;
      n_q         <= '0;
      k_q         <= '0;
      fetch_vld_q <= 1'b0;
    end else begin
      mem_a_q     <= bus.mem_a;
      mem_dout_q  <= bus.mem_dout;
      fetch_vld_q <= fetch_issue;
      if (grant_i) last_grant <= GNT_ICACHE;
      if (grant_d) begin
        last_grant <= GNT_DATA;
        addr_q     <= bus.data_addr;
        we_q       <= bus.data_we;
        n_q        <= size_bytes(bus.data_size);
        wdata_q    <= bus.data_wdata;
        rdata_q    <= '0;
        k_q        <= '0;
      end
      if (rd_capture)          rdata_q[cap_idx] <= bus.mem_din;
      if (rd_issue || wr_fire) k_q <= k_q + 3'd1;
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: behavioural byte RAM, expected fetch bytes and
// data completions queued at stimulus time and compared when the DUT produces them.
module tb_mem_arbiter;

  localparam int AW = 17;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  mem_arbiter_if #(.ADDR_W(AW)) bus ();
  mem_arbiter #(.ADDR_W(AW)) dut (.clk(clk), .rst(rst), .bus(bus));

  logic [7:0] ram [0:(1<<AW)-1];

  // Registered-read RAM: data for an address appears one cycle later.
  always @(posedge clk) begin
    bus.mem_din <= ram[bus.mem_a];
    if (bus.mem_wr) ram[bus.mem_a] = bus.mem_dout;
  end

  typedef struct {
    logic [31:0] rd;
    logic        ld;
    int          cyc;
  } dexp_t;

  logic [7:0] exp_ib [$];
  dexp_t      exp_dq [$];
  int n_chk  = 0;
  int n_pass = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at cycle %0d", tag, got, exp, cyc);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin : mon
    dexp_t e;
    if (bus.icache_out_en) begin
      if (exp_ib.size() == 0) check("ibyte_extra", 32'(bus.icache_out_en), 32'd0);
      else check("ibyte", 32'(bus.icache_byte), 32'(exp_ib.pop_front()));
    end
    if (bus.data_done) begin
      if (exp_dq.size() == 0) check("done_extra", 32'(bus.data_done), 32'd0);
      else begin
        e = exp_dq.pop_front();
        if (e.ld) check("rdata", bus.data_rdata, e.rd);
        check("done_cyc", 32'(cyc), 32'(e.cyc));
      end
    end
    if (bus.io_buffer_full) check("wr_stall", 32'(bus.mem_wr), 32'd0);
  end

  task automatic finish_data();
    step();
    bus.data_req       = 1'b0;
    bus.io_buffer_full = 1'b0;
    check("dq_drain", 32'(exp_dq.size()), 32'd0);
    exp_dq.delete();
  endtask

  task automatic wait_done();
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (bus.data_done) break;
    end
    finish_data();
  endtask

  task automatic do_fetch(input logic [AW-1:0] base, input int n);
    logic [AW-1:0] ak;
    step();
    for (int k = 0; k < n; k++) begin
      ak = base + AW'(k);
      exp_ib.push_back(ram[ak]);
    end
    bus.icache_addr   = base;
    bus.icache_get_en = 1'b1;
    for (int k = 0; k < n; k++) begin
      step();
      ak = base + AW'(k);
      bus.icache_addr = ak;
      @(negedge clk);
      check("f_mem_a", 32'(bus.mem_a), 32'(ak));
      check("f_oen", 32'(bus.icache_out_en), (k > 0) ? 32'd1 : 32'd0);
    end
    step();
    bus.icache_get_en = 1'b0;
    step();
    check("ib_drain", 32'(exp_ib.size()), 32'd0);
    exp_ib.delete();
  endtask

  task automatic do_data(input logic we, input logic [1:0] sz, input logic [AW-1:0] a,
                         input logic [31:0] wd, input logic [31:0] exp_rd,
                         input int st_at, input int st_len);
    int nb, g, lat;
    bit seen;
    logic [AW-1:0] ea;
    nb  = (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : 4;
    lat = we ? (nb + 1 + st_len) : (nb + 2);
    step();
    g = cyc;
    bus.data_req   = 1'b1;
    bus.data_we    = we;
    bus.data_size  = sz;
    bus.data_addr  = a;
    bus.data_wdata = wd;
    exp_dq.push_back('{rd: exp_rd, ld: !we, cyc: g + lat});
    seen = 1'b0;
    for (int i = 1; i < 60 && !seen; i++) begin
      step();
      bus.io_buffer_full = (st_len > 0) && (i >= st_at) && (i < st_at + st_len);
      @(negedge clk);
      if (st_len == 0 && i <= nb) begin
        ea = a + AW'(i - 1);
        check("d_mem_a", 32'(bus.mem_a), 32'(ea));
        check("d_mem_wr", 32'(bus.mem_wr), 32'(we));
      end
      seen = bus.data_done;
    end
    finish_data();
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: bench did not complete in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n0;
    bus.flush          = 1'b0;
    bus.icache_get_en  = 1'b1;
    bus.icache_addr    = 17'h00200;
    bus.data_req       = 1'b1;
    bus.data_we        = 1'b0;
    bus.data_size      = 2'b00;
    bus.data_addr      = 17'h00010;
    bus.data_wdata     = 32'h0;
    bus.io_buffer_full = 1'b0;
    for (int i = 0; i < (1 << AW); i++) ram[i] = 8'h00;
    ram[17'h00010] = 8'h5A;
    ram[17'h00200] = 8'h77;
    ram[17'h00100] = 8'h13; ram[17'h00101] = 8'h05; ram[17'h00102] = 8'h00; ram[17'h00103] = 8'h00;
    ram[17'h1FFFE] = 8'hAA; ram[17'h1FFFF] = 8'hBB; ram[17'h00000] = 8'hCC; ram[17'h00001] = 8'hDD;
    ram[17'h00020] = 8'hC3; ram[17'h00300] = 8'h9E; ram[17'h00030] = 8'h4B;
    ram[17'h00104] = 8'hE1; ram[17'h00105] = 8'hE2; ram[17'h00106] = 8'hE3;

    // Reset held two cycles with both requests up: nothing may move.
    step(); step();
    @(negedge clk);
    check("rst_mem_a",  32'(bus.mem_a), 32'd0);
    check("rst_mem_wr", 32'(bus.mem_wr), 32'd0);
    check("rst_dout",   32'(bus.mem_dout), 32'd0);
    check("rst_oen",    32'(bus.icache_out_en), 32'd0);
    check("rst_ibyte",  32'(bus.icache_byte), 32'd0);
    check("rst_done",   32'(bus.data_done), 32'd0);
    check("rst_rdata",  bus.data_rdata, 32'd0);
    rst = 1'b1;
    n0 = cyc;
    exp_ib.push_back(8'h77);
    exp_dq.push_back('{rd: 32'h5A, ld: 1'b1, cyc: n0 + 3 + 3});
    step();
    @(negedge clk);
    check("rel_ic_grant", 32'(bus.mem_a), 32'h200);
    step();
    bus.icache_get_en = 1'b0;
    wait_done();
    check("ib_drain", 32'(exp_ib.size()), 32'd0);
    exp_ib.delete();

    // ICache line fill.
    do_fetch(17'h00100, 4);

    // Loads/stores, including address wrap and write stall.
    do_data(1'b0, 2'b10, 17'h1FFFE, 32'h0, 32'hDDCCBBAA, 0, 0);
    do_data(1'b1, 2'b01, 17'h00040, 32'h00001234, 32'h0, 2, 3);
    check("st_b0", 32'(ram[17'h00040]), 32'h34);
    check("st_b1", 32'(ram[17'h00041]), 32'h12);
    check("st_b2", 32'(ram[17'h00042]), 32'h00);
    do_data(1'b1, 2'b10, 17'h00050, 32'hCAFEF00D, 32'h0, 0, 0);
    check("st4_b0", 32'(ram[17'h00050]), 32'h0D);
    check("st4_b3", 32'(ram[17'h00053]), 32'hCA);
    do_data(1'b0, 2'b10, 17'h00050, 32'h0, 32'hCAFEF00D, 0, 0);
    do_data(1'b0, 2'b01, 17'h00100, 32'h0, 32'h00000513, 0, 0);

    // Simultaneous requests in two consecutive IDLE windows alternate.
    step();
    n0 = cyc;
    bus.icache_addr   = 17'h00300;
    bus.icache_get_en = 1'b1;
    bus.data_req      = 1'b1;
    bus.data_we       = 1'b0;
    bus.data_size     = 2'b00;
    bus.data_addr     = 17'h00020;
    exp_ib.push_back(8'h9E);
    step();
    @(negedge clk);
    check("arb1_icache", 32'(bus.mem_a), 32'h300);
    step();
    bus.icache_get_en = 1'b0;
    step();
    bus.icache_get_en = 1'b1;
    bus.icache_addr   = 17'h00301;
    exp_dq.push_back('{rd: 32'hC3, ld: 1'b1, cyc: n0 + 3 + 3});
    step();
    @(negedge clk);
    check("arb2_data", 32'(bus.mem_a), 32'h20);
    bus.icache_get_en = 1'b0;
    wait_done();
    check("ib_drain", 32'(exp_ib.size()), 32'd0);
    exp_ib.delete();

    // Flush after two fetched bytes; pending load wins the next grant.
    step();
    n0 = cyc;
    bus.icache_addr   = 17'h00104;
    bus.icache_get_en = 1'b1;
    exp_ib.push_back(8'hE1);
    exp_ib.push_back(8'hE2);
    step();
    bus.data_req  = 1'b1;
    bus.data_we   = 1'b0;
    bus.data_size = 2'b00;
    bus.data_addr = 17'h00030;
    step();
    bus.icache_addr = 17'h00105;
    step();
    bus.icache_addr = 17'h00106;
    step();
    bus.flush       = 1'b1;
    bus.icache_addr = 17'h00107;
    @(negedge clk);
    check("fl_oen", 32'(bus.icache_out_en), 32'd0);
    step();
    bus.flush       = 1'b0;
    bus.icache_addr = 17'h01555;
    exp_dq.push_back('{rd: 32'h4B, ld: 1'b1, cyc: n0 + 5 + 3});
    @(negedge clk);
    check("fl_idle_hold", 32'(bus.mem_a), 32'h107);
    step();
    bus.icache_get_en = 1'b0;
    @(negedge clk);
    check("fl_data_grant", 32'(bus.mem_a), 32'h30);
    wait_done();
    check("ib_drain", 32'(exp_ib.size()), 32'd0);
    exp_ib.delete();

    step(); step();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
